// File: rtl/toggle_cov_pkg.sv
// Shared constants and helpers for the toggle coverage detector.
// Event vectors interleave per-bit edges: even index = rise, odd index = fall.
package toggle_cov_pkg;

    // Offset of each edge kind inside a per-bit event pair.
    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;

    // Position of an edge event for monitored bit bit_i in the event vector.
    function automatic int ev_idx(input int bit_i, input int is_fall);
        return 2 * bit_i + is_fall;
    endfunction

    // Width needed to hold a count from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : toggle_cov_pkg

// File: rtl/toggle_popcount.sv
// Combinational population count of an N-bit vector.
// Output is wide enough to hold N itself, so it never wraps.
module toggle_popcount
    import toggle_cov_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]          bits,
    output logic [cnt_w(N)-1:0]   count
);

    localparam int CW = cnt_w(N);

    // Sum the ones one bit at a time; synthesis folds this into an adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : toggle_popcount

// File: rtl/toggle_cover_detector.sv
// Per-bit toggle detector feeding a 2*W-wide toggle coverage sink.
// After a warm-up of WARMUP accepted samples, every sampled rise/fall of
// sig is reported as a one-cycle pulse on valid and recorded in a sticky
// covered bitmap with a running count of distinct events seen.
module toggle_cover_detector
    import toggle_cov_pkg::*;
#(
    parameter int W              = 3,
    parameter int WARMUP         = 2,
    parameter bit FIRST_HIT_ONLY = 1'b0
) (
    input  logic                       gbl_clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [W-1:0]               sig,
    input  logic                       clear_hits,
    output logic [2*W-1:0]             valid,
    output logic [2*W-1:0]             covered,
    output logic [cnt_w(2*W)-1:0]      covered_cnt,
    output logic                       all_covered,
    output logic                       armed
);

    localparam int EW  = 2 * W;
    localparam int CW  = cnt_w(EW);
    // Warm-up counter only needs to reach WARMUP-1; keep at least one bit.
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0] WARM_LAST = (WARMUP > 0) ? WCW'(WARMUP - 1) : '0;
    localparam logic [CW-1:0]  CNT_FULL  = CW'(EW);

    logic [W-1:0]   prev;
    logic           prev_valid;
    logic [WCW-1:0] warm_cnt;

    logic [EW-1:0]  ev;
    logic [EW-1:0]  rep;
    logic [EW-1:0]  new_hits;
    logic [CW-1:0]  new_cnt;
    logic [CW-1:0]  cnt_next;
    logic           detect;

    // Detection only counts edges between two real samples taken while armed.
    assign detect = sample_en & armed & prev_valid;

    // Raw per-bit edge events, interleaved rise/fall per monitored bit.
    always_comb begin
        ev = '0;
        for (int i = 0; i < W; i++) begin
            ev[ev_idx(i, EV_RISE)] = detect & ~prev[i] &  sig[i];
            ev[ev_idx(i, EV_FALL)] = detect &  prev[i] & ~sig[i];
        end
    end

    // Events not yet in the bitmap; uses covered as it stood before any clear.
    assign new_hits = ev & ~covered;

    // Reported events: everything, or only first hits when FIRST_HIT_ONLY is set.
    always_comb begin
        rep = ev;
        if (FIRST_HIT_ONLY) begin
            rep = new_hits;
        end
    end

    toggle_popcount #(
        .N (EW)
    ) u_popcount (
        .bits  (new_hits),
        .count (new_cnt)
    );

    // New hits are disjoint from covered, so the sum is bounded by EW.
    assign cnt_next = covered_cnt + new_cnt;

    // Sample register: prev follows sig only on accepted samples.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= sig;
            prev_valid <= 1'b1;
        end
    end

    // Warm-up: count accepted samples until WARMUP have been seen, then arm.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else if (WARMUP == 0) begin
            armed <= 1'b1;
        end else if (sample_en && !armed) begin
            if (warm_cnt == WARM_LAST) begin
                armed <= 1'b1;
            end else begin
                warm_cnt <= warm_cnt + WCW'(1);
            end
        end
    end

    // Event pulse: valid carries this cycle's reported events for one cycle.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            valid <= rep;
        end
    end

    // Sticky coverage: clear wins over recording same-cycle events.
    always_ff @(posedge gbl_clk) begin
        if (!reset || clear_hits) begin
            covered     <= '0;
            covered_cnt <= '0;
            all_covered <= 1'b0;
        end else begin
            covered     <= covered | ev;
            covered_cnt <= cnt_next;
            all_covered <= (cnt_next == CNT_FULL);
        end
    end

endmodule : toggle_cover_detector

// File: tb/tb_toggle_cover_detector.sv
// Bench for toggle_cover_detector: three instances share stimulus
// (FIRST_HIT_ONLY=0/WARMUP=2, FIRST_HIT_ONLY=1/WARMUP=2, FIRST_HIT_ONLY=0/WARMUP=0)
// and are compared every cycle against a sample-history model, plus pinned literals.
module tb_toggle_cover_detector;

    localparam int W  = 3;
    localparam int EW = 2 * W;
    localparam int NI = 3;

    // ---------------- clock / reset ----------------
    logic gbl_clk = 1'b0;
    always #5 gbl_clk = ~gbl_clk;

    logic          reset      = 1'b0;
    logic          sample_en  = 1'b0;
    logic [W-1:0]  sig        = '0;
    logic          clear_hits = 1'b0;

    logic [EW-1:0] d_valid   [NI];
    logic [EW-1:0] d_covered [NI];
    logic [2:0]    d_cnt     [NI];
    logic          d_all     [NI];
    logic          d_armed   [NI];

    toggle_cover_detector #(.W(W), .WARMUP(2), .FIRST_HIT_ONLY(1'b0)) dut0 (
        .gbl_clk(gbl_clk), .reset(reset), .sample_en(sample_en), .sig(sig),
        .clear_hits(clear_hits), .valid(d_valid[0]), .covered(d_covered[0]),
        .covered_cnt(d_cnt[0]), .all_covered(d_all[0]), .armed(d_armed[0]));

    toggle_cover_detector #(.W(W), .WARMUP(2), .FIRST_HIT_ONLY(1'b1)) dut1 (
        .gbl_clk(gbl_clk), .reset(reset), .sample_en(sample_en), .sig(sig),
        .clear_hits(clear_hits), .valid(d_valid[1]), .covered(d_covered[1]),
        .covered_cnt(d_cnt[1]), .all_covered(d_all[1]), .armed(d_armed[1]));

    toggle_cover_detector #(.W(W), .WARMUP(0), .FIRST_HIT_ONLY(1'b0)) dut2 (
        .gbl_clk(gbl_clk), .reset(reset), .sample_en(sample_en), .sig(sig),
        .clear_hits(clear_hits), .valid(d_valid[2]), .covered(d_covered[2]),
        .covered_cnt(d_cnt[2]), .all_covered(d_all[2]), .armed(d_armed[2]));

    // ---------------- model ----------------
    // Tracks the last accepted sample, how many samples were taken since reset,
    // and the set of events ever seen since the last clear.
    int            wu_tab  [NI] = '{2, 2, 0};
    bit            fho_tab [NI] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0]  m_prev  [NI];
    bit            m_have  [NI];
    int            m_nsamp [NI];
    bit            m_armed [NI];
    logic [EW-1:0] m_valid [NI];
    logic [EW-1:0] m_cov   [NI];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic model_edge(input bit rst_n, input bit se, input logic [W-1:0] s, input bit clr);
        logic [EW-1:0] ev;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_prev[k] = '0; m_have[k] = 0; m_nsamp[k] = 0; m_armed[k] = 0;
                m_valid[k] = '0; m_cov[k] = '0;
            end else begin
                ev = '0;
                if (se && m_armed[k] && m_have[k]) begin
                    for (int b = 0; b < W; b++) begin
                        if (m_prev[k][b] == 1'b0 && s[b] == 1'b1) ev[2*b]   = 1'b1;
                        if (m_prev[k][b] == 1'b1 && s[b] == 1'b0) ev[2*b+1] = 1'b1;
                    end
                end
                m_valid[k] = fho_tab[k] ? (ev & ~m_cov[k]) : ev;
                m_cov[k]   = clr ? '0 : (m_cov[k] | ev);
                if (se) begin
                    m_prev[k] = s;
                    m_have[k] = 1;
                    if (m_nsamp[k] < 1000) m_nsamp[k]++;
                end
                m_armed[k] = (m_nsamp[k] >= wu_tab[k]);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after the first reset edge, all outputs of all instances track the model.
    always @(negedge gbl_clk) begin
        if (chk_on) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("m%0d_valid", k),   32'(d_valid[k]),   32'(m_valid[k]));
                chk($sformatf("m%0d_covered", k), 32'(d_covered[k]), 32'(m_cov[k]));
                chk($sformatf("m%0d_cnt", k),     32'(d_cnt[k]),     32'($countones(m_cov[k])));
                chk($sformatf("m%0d_all", k),     32'(d_all[k]),     32'(m_cov[k] == '1));
                chk($sformatf("m%0d_armed", k),   32'(d_armed[k]),   32'(m_armed[k]));
            end
        end
    end

    // ---------------- driver ----------------
    // Drive at negedge, let one posedge pass, update the model, return at negedge.
    task automatic step(input bit se, input logic [W-1:0] s, input bit clr, input bit rst_n);
        sample_en = se; sig = s; clear_hits = clr; reset = rst_n;
        @(posedge gbl_clk);
        model_edge(rst_n, se, s, clr);
        @(negedge gbl_clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset two cycles
        step(0, 3'b000, 0, 0);
        chk_on = 1'b1;
        step(0, 3'b000, 0, 0);
        chk("rst_valid", 32'(d_valid[0]), 32'h0);
        chk("rst_cnt",   32'(d_cnt[0]),   32'h0);
        chk("rst_armed", 32'(d_armed[0]), 32'h0);

        // Warm-up samples 000, 111 are ignored; armed after the 2nd
        step(1, 3'b000, 0, 1);
        chk("wu1_valid", 32'(d_valid[0]), 32'h0);
        chk("wu1_armed", 32'(d_armed[0]), 32'h0);
        chk("wu0_armed", 32'(d_armed[2]), 32'h1);
        step(1, 3'b111, 0, 1);
        chk("wu2_valid", 32'(d_valid[0]), 32'h0);
        chk("wu2_armed", 32'(d_armed[0]), 32'h1);
        step(1, 3'b000, 0, 1);

        // Clear with no sample, leaving prev=000
        step(0, 3'b000, 1, 1);
        chk("clr_cov", 32'(d_covered[0]), 32'h0);

        // 000 -> 101
        step(1, 3'b101, 0, 1);
        chk("t2_valid", 32'(d_valid[0]),   32'b010001);
        chk("t2_cov",   32'(d_covered[0]), 32'b010001);
        chk("t2_cnt",   32'(d_cnt[0]),     32'd2);

        // First-hit-only: 101 -> 000 -> 101
        step(1, 3'b000, 0, 1);
        chk("t3_fall", 32'(d_valid[1]), 32'b100010);
        step(1, 3'b101, 0, 1);
        chk("t3_rep",  32'(d_valid[1]), 32'h0);
        chk("t3_cnt",  32'(d_cnt[1]),   32'd4);
        chk("t3_all_rep", 32'(d_valid[0]), 32'b010001);

        // Disabled sampling: prev held at 000
        step(1, 3'b000, 0, 1);
        step(0, 3'b000, 0, 1);
        step(0, 3'b011, 0, 1);
        chk("t4_off1", 32'(d_valid[0]), 32'h0);
        step(0, 3'b000, 0, 1);
        step(0, 3'b010, 0, 1);
        chk("t4_off2", 32'(d_valid[0]), 32'h0);
        step(1, 3'b010, 0, 1);
        chk("t4_valid", 32'(d_valid[0]), 32'b000100);

        // Event coinciding with clear
        step(1, 3'b000, 0, 1);
        step(1, 3'b001, 1, 1);
        chk("t5_valid", 32'(d_valid[0]),   32'b000001);
        chk("t5_cov",   32'(d_covered[0]), 32'h0);
        chk("t5_cnt",   32'(d_cnt[0]),     32'h0);

        // All six edges
        step(1, 3'b000, 0, 1);
        step(1, 3'b111, 0, 1);
        chk("t6_multi", 32'(d_valid[0]), 32'b010101);
        step(1, 3'b000, 0, 1);
        chk("t6_cnt", 32'(d_cnt[0]), 32'd6);
        chk("t6_all", 32'(d_all[0]), 32'h1);

        // Mid-run reset restarts warm-up
        step(1, 3'b111, 0, 0);
        chk("r_valid", 32'(d_valid[0]),   32'h0);
        chk("r_cov",   32'(d_covered[0]), 32'h0);
        chk("r_cnt",   32'(d_cnt[0]),     32'h0);
        chk("r_all",   32'(d_all[0]),     32'h0);
        chk("r_armed", 32'(d_armed[0]),   32'h0);
        chk("r_armed0", 32'(d_armed[2]),  32'h0);
        step(1, 3'b111, 0, 1);
        chk("rw1_valid", 32'(d_valid[0]), 32'h0);
        chk("rw1_armed", 32'(d_armed[0]), 32'h0);
        step(1, 3'b000, 0, 1);
        chk("rw2_valid", 32'(d_valid[0]), 32'h0);
        chk("rw2_armed", 32'(d_armed[0]), 32'h1);
        chk("rw2_wu0",   32'(d_valid[2]), 32'b101010);

        // A few more mixed patterns for the model to track
        step(1, 3'b110, 0, 1);
        step(1, 3'b011, 0, 1);
        step(0, 3'b100, 0, 1);
        step(1, 3'b100, 0, 1);
        step(1, 3'b100, 0, 1);
        step(1, 3'b001, 1, 1);
        step(1, 3'b110, 0, 1);
        step(0, 3'b000, 0, 1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_toggle_cover_detector
